// File: rtl/psum_shift_accumulator.sv
// psum_shift_accumulator
//
// Post-ADC stage of the in-memory-compute macro. Each activation bit plane
// delivers one ADC partial-sum word per column, MSB plane first. The planes
// are shift-accumulated into per-column multibit dot-product results, which
// are then offered downstream on a valid/ready handshake.
//
// Optional feature macro: PSUM_SIGNED_ACT_EN
//   defined   : two's complement activations, so the first (MSB) plane is
//               loaded negated (acc = -sext(psum)).
//   undefined : unsigned activations, so the first plane is loaded as
//               acc = sext(psum).
//
// Ports:
//   clk        in   clock, rising edge
//   nrst       in   asynchronous active-low reset
//   clr        in   synchronous abort, discards partial accumulation
//   psum_in    in   packed ADC words, column c at [c*ADC_BITS +: ADC_BITS]
//   psum_valid in   psum_in holds the next bit plane
//   psum_ready out  a plane can be accepted this cycle
//   acc_out    out  packed results, column c at [c*ACC_BITS +: ACC_BITS]
//   acc_valid  out  acc_out holds a complete result
//   acc_ready  in   downstream consumes the result
//   plane_idx  out  index of the next expected plane (MSB = IN_BITS-1)
//   busy       out  accumulating or holding a result

module psum_shift_accumulator #(
  parameter int unsigned NUM_COLS = 32,
  parameter int unsigned ADC_BITS = 4,
  parameter int unsigned IN_BITS  = 4,
  parameter int unsigned ACC_BITS = 16,
  localparam int unsigned IDX_W   = (IN_BITS > 1) ? $clog2(IN_BITS) : 1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         clr,
  input  logic [NUM_COLS*ADC_BITS-1:0] psum_in,
  input  logic                         psum_valid,
  output logic                         psum_ready,
  output logic [NUM_COLS*ACC_BITS-1:0] acc_out,
  output logic                         acc_valid,
  input  logic                         acc_ready,
  output logic [IDX_W-1:0]             plane_idx,
  output logic                         busy
);

  // The accumulator must hold the full weighted sum without overflow.
  if (ACC_BITS < ADC_BITS + IN_BITS + 1) begin : g_acc_width_check
    $error("psum_shift_accumulator: ACC_BITS must be >= ADC_BITS+IN_BITS+1");
  end
  if (IN_BITS < 2) begin : g_in_bits_check
    $error("psum_shift_accumulator: IN_BITS must be >= 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  localparam logic [IDX_W-1:0] IdxMsb   = IDX_W'(IN_BITS - 1);
  localparam logic [IDX_W-1:0] IdxFirst = IDX_W'(IN_BITS - 2);

  state_e                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_psum_ready;
  logic                         r_acc_valid;
  logic                         r_busy;
  logic [NUM_COLS*ACC_BITS-1:0] r_acc_out;
  logic [ACC_BITS-1:0]          r_acc [NUM_COLS];

  logic                         w_accept;
  logic [ACC_BITS-1:0]          w_sext  [NUM_COLS];
  logic [ACC_BITS-1:0]          w_first [NUM_COLS];
  logic [ACC_BITS-1:0]          w_shadd [NUM_COLS];
  logic [NUM_COLS*ACC_BITS-1:0] w_shadd_flat;

  assign w_accept = psum_valid & r_psum_ready;

  // Per-column datapath: sign extension, first-plane load value and the
  // shift-add used for every later plane.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [ADC_BITS-1:0] w_psum;
    assign w_psum = psum_in[c*ADC_BITS +: ADC_BITS];
    assign w_sext[c] = {{(ACC_BITS - ADC_BITS){w_psum[ADC_BITS-1]}}, w_psum};
`ifdef PSUM_SIGNED_ACT_EN
    // MSB activation plane carries weight -2^(IN_BITS-1).
    assign w_first[c] = '0 - w_sext[c];
`else
    assign w_first[c] = w_sext[c];
`endif
    // Left shift of a two's complement value is the same for arithmetic and
    // logical shift; bound on ACC_BITS keeps the sign bit intact.
    assign w_shadd[c] = {r_acc[c][ACC_BITS-2:0], 1'b0} + w_sext[c];
    assign w_shadd_flat[c*ACC_BITS +: ACC_BITS] = w_shadd[c];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= StIdle;
      r_idx        <= IdxMsb;
      r_psum_ready <= 1'b1;
      r_acc_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_acc_out    <= '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        r_acc[c] <= '0;
      end
    end else if (clr) begin
      // Abort wins over everything; acc_out keeps the last delivered result.
      r_state      <= StIdle;
      r_idx        <= IdxMsb;
      r_psum_ready <= 1'b1;
      r_acc_valid  <= 1'b0;
      r_busy       <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) begin
        r_acc[c] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            for (int c = 0; c < NUM_COLS; c++) begin
              r_acc[c] <= w_first[c];
            end
            r_idx   <= IdxFirst;
            r_state <= StAccum;
            r_busy  <= 1'b1;
          end
        end
        StAccum: begin
          if (w_accept) begin
            for (int c = 0; c < NUM_COLS; c++) begin
              r_acc[c] <= w_shadd[c];
            end
            if (r_idx == '0) begin
              // LSB plane: result is complete on this edge.
              r_state      <= StHold;
              r_psum_ready <= 1'b0;
              r_acc_valid  <= 1'b1;
              r_acc_out    <= w_shadd_flat;
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end
        end
        StHold: begin
          if (acc_ready) begin
            r_state      <= StIdle;
            r_idx        <= IdxMsb;
            r_psum_ready <= 1'b1;
            r_acc_valid  <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= StIdle;
          r_idx        <= IdxMsb;
          r_psum_ready <= 1'b1;
          r_acc_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign psum_ready = r_psum_ready;
  assign acc_out    = r_acc_out;
  assign acc_valid  = r_acc_valid;
  assign plane_idx  = r_idx;
  assign busy       = r_busy;

endmodule

// File: tb/tb_psum_shift_accumulator.sv
// Self-checking bench for psum_shift_accumulator: directed steps plus a
// random sweep, expected results held in a scoreboard queue.

module tb_psum_shift_accumulator;

  localparam int unsigned NUM_COLS = 32;
  localparam int unsigned ADC_BITS = 4;
  localparam int unsigned IN_BITS  = 4;
  localparam int unsigned ACC_BITS = 16;
  localparam int unsigned IDX_W    = $clog2(IN_BITS);
  localparam int unsigned W_IN     = NUM_COLS * ADC_BITS;
  localparam int unsigned W_OUT    = NUM_COLS * ACC_BITS;

  logic             clk;
  logic             nrst;
  logic             clr;
  logic [W_IN-1:0]  psum_in;
  logic             psum_valid;
  logic             psum_ready;
  logic [W_OUT-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic [IDX_W-1:0] plane_idx;
  logic             busy;

  psum_shift_accumulator #(
    .NUM_COLS (NUM_COLS),
    .ADC_BITS (ADC_BITS),
    .IN_BITS  (IN_BITS),
    .ACC_BITS (ACC_BITS)
  ) u_dut (
    .clk        (clk),
    .nrst       (nrst),
    .clr        (clr),
    .psum_in    (psum_in),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .plane_idx  (plane_idx),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned      n_tests;
  int unsigned      n_fail;
  logic [W_IN-1:0]  planes [IN_BITS];
  logic [W_OUT-1:0] sb_q [$];
  logic [W_OUT-1:0] last_result;

  task automatic check(input string tag, input logic [W_OUT-1:0] obs,
                       input logic [W_OUT-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: weighted sum of sign-extended ADC words, MSB plane weight
  // negated for signed activations.
  function automatic logic [W_OUT-1:0] model(input logic [W_IN-1:0] pl [IN_BITS]);
    logic [W_OUT-1:0] res;
    res = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      longint s;
      s = 0;
      for (int k = 0; k < IN_BITS; k++) begin
        longint v;
        longint wgt;
        logic [ADC_BITS-1:0] raw;
        raw = pl[k][c*ADC_BITS +: ADC_BITS];
        v   = longint'($signed(raw));
        wgt = longint'(1) << (IN_BITS - 1 - k);
`ifdef PSUM_SIGNED_ACT_EN
        if (k == 0) wgt = -wgt;
`endif
        s = s + v * wgt;
      end
      res[c*ACC_BITS +: ACC_BITS] = s[ACC_BITS-1:0];
    end
    return res;
  endfunction

  // Drive planes[] with 'gap' idle cycles after each plane; push expected
  // result when the run starts and check plane_idx progression.
  task automatic run_planes(input string tag, input int gap);
    sb_q.push_back(model(planes));
    for (int k = 0; k < IN_BITS; k++) begin
      check({tag, " plane_idx"}, W_OUT'(plane_idx), W_OUT'(IN_BITS - 1 - k));
      psum_in    = planes[k];
      psum_valid = 1'b1;
      tick();
      psum_valid = 1'b0;
      psum_in    = '0;
      if (k == IN_BITS - 1) begin
        check({tag, " valid_on_lsb_edge"}, W_OUT'(acc_valid), W_OUT'(1'b1));
      end else begin
        check({tag, " valid_early"}, W_OUT'(acc_valid), W_OUT'(1'b0));
      end
      for (int g = 0; g < gap && k != IN_BITS - 1; g++) begin
        tick();
        check({tag, " idx_stall"}, W_OUT'(plane_idx), W_OUT'(IN_BITS - 2 - k));
      end
    end
  endtask

  task automatic wait_result(input string tag);
    int n;
    logic [W_OUT-1:0] exp;
    n = 0;
    while (acc_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " acc_valid"}, W_OUT'(acc_valid), W_OUT'(1'b1));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check({tag, " acc_out"}, acc_out, exp);
    last_result = exp;
  endtask

  task automatic release_result(input string tag);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check({tag, " idle_valid"}, W_OUT'(acc_valid), W_OUT'(1'b0));
    check({tag, " idle_ready"}, W_OUT'(psum_ready), W_OUT'(1'b1));
    check({tag, " idle_idx"}, W_OUT'(plane_idx), W_OUT'(IN_BITS - 1));
    check({tag, " idle_busy"}, W_OUT'(busy), W_OUT'(1'b0));
  endtask

  task automatic load_directed();
    for (int k = 0; k < IN_BITS; k++) planes[k] = '0;
    planes[0][3:0] = 4'd1;
    planes[1][3:0] = 4'd2;
    planes[2][3:0] = 4'd3;
    planes[3][3:0] = 4'hF;
    for (int k = 0; k < IN_BITS; k++) planes[k][7:4] = 4'd7;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    last_result = '0;
    nrst        = 1'b0;
    clr         = 1'b0;
    psum_in     = '0;
    psum_valid  = 1'b0;
    acc_ready   = 1'b0;

    // Reset
    repeat (5) @(posedge clk);
    #1;
    nrst = 1'b1;
    tick();
    check("rst acc_valid", W_OUT'(acc_valid), W_OUT'(1'b0));
    check("rst psum_ready", W_OUT'(psum_ready), W_OUT'(1'b1));
    check("rst plane_idx", W_OUT'(plane_idx), W_OUT'(3));
    check("rst acc_out", acc_out, '0);
    check("rst busy", W_OUT'(busy), W_OUT'(1'b0));

    // Directed accumulation, back-to-back planes
    load_directed();
    run_planes("dir", 0);
`ifdef PSUM_SIGNED_ACT_EN
    check("dir col0", W_OUT'(acc_out[15:0]), W_OUT'(16'd5));
    check("dir col1", W_OUT'(acc_out[31:16]), W_OUT'(16'hFFF9));
`else
    check("dir col0", W_OUT'(acc_out[15:0]), W_OUT'(16'd21));
    check("dir col1", W_OUT'(acc_out[31:16]), W_OUT'(16'd105));
`endif
    wait_result("dir");
    check("dir busy", W_OUT'(busy), W_OUT'(1'b1));

    // Hold for 10 cycles; planes offered during the first 3 must be ignored
    for (int i = 0; i < 10; i++) begin
      psum_valid = (i < 3);
      psum_in    = {W_IN{1'b1}};
      check("hold psum_ready", W_OUT'(psum_ready), W_OUT'(1'b0));
      tick();
      check("hold acc_out", acc_out, last_result);
      check("hold acc_valid", W_OUT'(acc_valid), W_OUT'(1'b1));
    end
    psum_valid = 1'b0;
    psum_in    = '0;
    release_result("dir");
    check("after_handoff acc_out", acc_out, last_result);

    // Stalled upstream: valid toggles 1,0,1,0
    load_directed();
    run_planes("stall", 1);
    wait_result("stall");
    release_result("stall");

    // clr after two planes, with a plane presented in the same cycle
    load_directed();
    for (int k = 0; k < 2; k++) begin
      psum_in    = planes[k];
      psum_valid = 1'b1;
      tick();
    end
    psum_in = planes[2];
    clr     = 1'b1;
    tick();
    clr        = 1'b0;
    psum_valid = 1'b0;
    psum_in    = '0;
    check("clr plane_idx", W_OUT'(plane_idx), W_OUT'(3));
    check("clr acc_valid", W_OUT'(acc_valid), W_OUT'(1'b0));
    check("clr busy", W_OUT'(busy), W_OUT'(1'b0));
    check("clr acc_out_kept", acc_out, last_result);
    tick();
    check("clr no_late_valid", W_OUT'(acc_valid), W_OUT'(1'b0));
    // Fresh run with a different pattern exposes any residue
    for (int k = 0; k < IN_BITS; k++) planes[k] = {NUM_COLS{4'(k + 5)}};
    run_planes("post_clr", 0);
    wait_result("post_clr");

    // clr while holding a result withdraws it
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_hold acc_valid", W_OUT'(acc_valid), W_OUT'(1'b0));
    check("clr_hold psum_ready", W_OUT'(psum_ready), W_OUT'(1'b1));

    // Async reset while holding: outputs fall before the next edge
    load_directed();
    run_planes("arst", 0);
    wait_result("arst");
    #3;
    nrst = 1'b0;
    #1;
    check("arst acc_valid", W_OUT'(acc_valid), W_OUT'(1'b0));
    check("arst busy", W_OUT'(busy), W_OUT'(1'b0));
    check("arst plane_idx", W_OUT'(plane_idx), W_OUT'(3));
    check("arst acc_out", acc_out, '0);
    #2;
    nrst = 1'b1;
    tick();

    // Random sweep across all columns
    for (int v = 0; v < 200; v++) begin
      for (int k = 0; k < IN_BITS; k++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          planes[k][c*ADC_BITS +: ADC_BITS] = 4'($urandom_range(0, 15));
        end
      end
      run_planes("rand", (v % 3 == 0) ? 1 : 0);
      wait_result("rand");
      release_result("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_shift_accumulator.md
Name: psum_shift_accumulator

Overview:
- Post-ADC stage of the in-memory-compute macro: receives one ADC partial-sum word per column per activation bit plane, MSB plane first.
- Shift-accumulates the planes into multibit per-column dot-product results.
- Presents the results to the output buffer / top-level readout with a valid/ready handshake.

Parameters:
- NUM_COLS, 32, number of array columns processed in parallel
- ADC_BITS, 4, width of each column ADC output, two's complement
- IN_BITS, 4, activation bit planes per result (≥2)
- ACC_BITS, 16, per-column accumulator width; must satisfy ACC_BITS ≥ ADC_BITS+IN_BITS+1 (elaboration-time $error otherwise)

Ports:
- clk  in  1  clock, rising-edge
- nrst  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; discards partial accumulation
- psum_in  in  NUM_COLS*ADC_BITS  packed ADC outputs; column c is at bits [c*ADC_BITS +: ADC_BITS]
- psum_valid  in  1  psum_in holds the next bit plane
- psum_ready  out  1  block can accept a plane this cycle
- acc_out  out  NUM_COLS*ACC_BITS  packed per-column results; column c is at bits [c*ACC_BITS +: ACC_BITS]
- acc_valid  out  1  acc_out holds a complete result
- acc_ready  in  1  downstream consumes the result
- plane_idx  out  $clog2(IN_BITS)  index of the next plane expected, MSB plane = IN_BITS-1
- busy  out  1  high in ACCUM or HOLD

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset nrst.
- Reset values: state=IDLE, all accumulators 0, acc_out=0, acc_valid=0, psum_ready=1, plane_idx=IN_BITS-1, busy=0.
- States:
  - IDLE: psum_ready=1. An accepted plane (psum_valid&&psum_ready) loads the first-plane value into the accumulators and goes to ACCUM with plane_idx=IN_BITS-2.
  - ACCUM: psum_ready=1. Each accepted plane performs acc = (acc<<1) + sext(psum) per column and decrements plane_idx. When the accepted plane has plane_idx==0, go to HOLD.
  - HOLD: psum_ready=0, acc_valid=1, acc_out stable. On acc_ready: go to IDLE and reset plane_idx to IN_BITS-1.
- Latency: acc_valid rises on the clock edge that accepts the LSB plane. A result is available IN_BITS accepted cycles after the first plane.
- Throughput: one result every IN_BITS+1 cycles with ready continuously high. HOLD costs one cycle; back-to-back acceptance during HOLD is not supported.
- psum_valid low in IDLE/ACCUM: hold state; no accumulation.
- Arithmetic:
  - psum is sign-extended from ADC_BITS to ACC_BITS before use.
  - The shift is arithmetic.
  - The ACC_BITS bound guarantees no overflow; no saturation logic.
- acc_out is registered and updates only on the HOLD entry edge. It is otherwise unchanged, including after hand-off.
- clr:
  - Highest priority: next state=IDLE, accumulators=0, plane_idx=IN_BITS-1, acc_valid=0.
  - A plane presented in the same cycle is dropped.
  - acc_out keeps its last value.
  - In HOLD, clr withdraws the result even without acc_ready.
- psum_valid in HOLD is ignored because psum_ready=0. Upstream must hold the plane until ready.
- nrst mid-operation returns to the reset values immediately, asynchronously.
- busy = (state != IDLE).

Optional Feature:
- Macro PSUM_SIGNED_ACT_EN.
- Defined: activations are two's complement, so the MSB plane carries negative weight. The first-plane load is acc = -sext(psum).
- Undefined: activations are unsigned, and the first-plane load is acc = sext(psum).
- Both builds use the same shift-add for the remaining planes and the same ports.

Test Plan:
- Reset: hold nrst=0 for 5 clk, release → acc_valid=0, psum_ready=1, plane_idx=3, acc_out=0, busy=0.
- Unsigned accumulation (macro undefined, IN_BITS=4, ADC_BITS=4): col0 planes MSB→LSB 1,2,3,-1 with psum_valid continuously high, acc_ready=0 → acc_valid rises on the 4th accept edge; col0 acc_out=21; psum_ready=0 while held.
- Signed accumulation (PSUM_SIGNED_ACT_EN defined): same stimulus → col0=5; col1 planes 7,7,7,7 → col1=-7 (unsigned build: 105).
- Handshake stalls: psum_valid toggled 1,0,1,0,… → plane_idx advances only on accepted cycles and the result is identical. In HOLD, acc_ready held low 10 cycles → acc_out stable; then acc_ready=1 for one cycle → IDLE next cycle.
- clr mid-operation: clr=1 with psum_valid=1 after 2 planes → that plane is dropped, plane_idx=3, acc_valid stays 0. A subsequent fresh 4-plane run gives the correct result with no residue.
- Async reset in HOLD: drop nrst between clk edges → acc_valid and busy fall immediately without waiting for the next edge. All columns (NUM_COLS=32) are checked against a reference model over 200 random vectors.
